// File: rtl/aes_ctrl_pkg.sv
// Shared encodings and helpers for the AES round sequencer: phase codes,
// per-key-length round counts and the switch-to-mode decode.
package aes_ctrl_pkg;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_ENC  = 2'd1;
    localparam logic [1:0] PH_DEC  = 2'd2;
    localparam logic [1:0] PH_DONE = 2'd3;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] nr_of(input logic [1:0] m);
        logic [3:0] nr;
        case (m)
            2'd1:    nr = NR_192;
            2'd2:    nr = NR_256;
            default: nr = NR_128;
        endcase
        return nr;
    endfunction

    // 2'b11 is not a legal key length and falls back to AES-128.
    function automatic logic [1:0] sw_to_mode(input logic [1:0] sw);
        logic [1:0] m;
        case (sw)
            2'b01:   m = 2'd1;
            2'b10:   m = 2'd2;
            default: m = 2'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Round controller for the iterative AES datapath: one encryption pass followed
// by the matching decryption pass, free-running or single-stepped.
module aes_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned STEP_DEFAULT = 0,
    parameter int unsigned MAX_NR       = 14
) (
    input  logic       KEY,
    input  logic       rst,
    input  logic [1:0] SW,
    input  logic       start,
    input  logic       step_mode,
    input  logic       step,
    input  logic       match,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [1:0] mode,
    output logic [1:0] phase,
    output logic [3:0] round,
    output logic [4:0] disp_round,
    output logic [3:0] rk_index,
    output logic       ld_state,
    output logic       last_round
);

    if (MAX_NR < 32'(NR_256) || MAX_NR > 15) begin : g_bad_max_nr
        $error("MAX_NR must cover 14 rounds and fit the 4-bit round port");
    end
    if (STEP_DEFAULT > 1) begin : g_bad_step_default
        $error("STEP_DEFAULT is a single-bit tie-off value");
    end

    logic [3:0] nr;
    logic       adv;
    logic       at_last;

    assign nr      = nr_of(mode);
    assign adv     = !step_mode || step;
    assign at_last = (round == nr);

    always_ff @(posedge KEY) begin
        if (!rst) begin
            phase <= PH_IDLE;
            round <= '0;
            mode  <= '0;
            pass  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (phase)
                PH_IDLE, PH_DONE: begin
                    if (start) begin
                        mode  <= sw_to_mode(SW);
                        phase <= PH_ENC;
                        round <= '0;
                        pass  <= 1'b0;
                    end
                end
                PH_ENC: begin
                    if (adv) begin
                        if (at_last) begin
                            phase <= PH_DEC;
                            round <= '0;
                        end else begin
                            round <= round + 4'd1;
                        end
                    end
                end
                default: begin
                    // DEC: round stays at Nr on exit so DONE keeps showing it.
                    if (adv) begin
                        if (at_last) begin
                            phase <= PH_DONE;
                            done  <= 1'b1;
                            pass  <= match;
                        end else begin
                            round <= round + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy       = (phase == PH_ENC) || (phase == PH_DEC);
    assign ld_state   = busy && (round == 4'd0);
    assign last_round = busy && at_last;

    always_comb begin
        disp_round = '0;
        rk_index   = '0;
        case (phase)
            PH_ENC: begin
                disp_round = {1'b0, round};
                rk_index   = round;
            end
            PH_DEC: begin
                disp_round = {1'b0, nr} + 5'd1 + {1'b0, round};
                rk_index   = nr - round;
            end
            PH_DONE: begin
                disp_round = {nr, 1'b1};
            end
            default: begin
                disp_round = '0;
                rk_index   = '0;
            end
        endcase
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Controller for the iterative AES datapath.
- Latches the key-length mode from the switches on a start request.
- Sequences one full encryption pass (rounds 0..Nr), then the matching decryption pass, and reports done/pass.
- Drives the cipher/decipher round-select, round-key index and state-load strobes, plus the global round count used by the seven-segment round display.
- Supports free-run and single-step (one round per step pulse) operation.

Parameters:
STEP_DEFAULT, 0, step_mode assumed when unconnected (tie-off value only)
MAX_NR, 14, largest round count supported; sizes the round counters

Ports:
KEY  input  1  clock
rst  input  1  reset, synchronous, active-low
SW  input  2  key-length select: 01=192, 10=256, 00/11=128
start  input  1  begin a run; level-sampled; honoured only in IDLE or DONE
step_mode  input  1  1 = rounds advance only on step, 0 = one round per clock
step  input  1  single-cycle advance request (pre-debounced, pre-synchronised)
match  input  1  decipher output equals plaintext (combinational from datapath)
busy  output  1  high in ENC and DEC
done  output  1  one-cycle pulse on entry to DONE
pass  output  1  registered result of the run
mode  output  2  latched selector, 0/1/2
phase  output  2  0=IDLE 1=ENC 2=DEC 3=DONE
round  output  4  round within the current phase, 0..Nr
disp_round  output  5  global count: ENC r -> r, DEC r -> Nr+1+r
rk_index  output  4  round-key index: ENC = round, DEC = Nr-round
ld_state  output  1  load input block into state register (round 0 of ENC or DEC)
last_round  output  1  round==Nr in ENC or DEC (omit MixColumns)

Behaviour:
Nr derivation
- Nr = 10 + 2*mode, giving 10/12/14.
- Computed from the latched mode only; SW changes outside IDLE/DONE are ignored.

Reset (rst=0 at a KEY edge)
- phase=IDLE; round, disp_round, rk_index, mode = 0.
- busy, done, pass, ld_state, last_round = 0.
- Applies mid-run; the run is abandoned with no done pulse.

Advance condition
- adv = !step_mode | step.
- step is ignored when step_mode=0.
- A step outside ENC/DEC is ignored.

IDLE / DONE, start=1 at an edge
- mode <= decode(SW); phase <= ENC; round <= 0; pass <= 0.
- First ENC cycle appears one clock after the start edge.

ENC
- On adv: round+1.
- At round==Nr with adv: phase <= DEC, round <= 0.
- Without adv: all outputs hold.

DEC
- On adv: round+1.
- At round==Nr with adv: phase <= DONE, done=1 for one cycle, pass <= match sampled at that edge.

DONE
- round holds Nr; disp_round holds 2Nr+1; pass held.
- start restarts the run and clears pass in the same edge.

Other rules
- start while busy is ignored; no queueing.
- ld_state = (phase in ENC/DEC) & round==0; combinational from registered state.
- last_round is combinational from registered state.
- Free-run latency, start edge to done pulse: 2Nr+2 edges (22/26/30).
- All outputs are registered or decoded from registers; no input-to-output combinational path except none.
- disp_round never exceeds 29.

Decomposition:
- Package aes_ctrl_pkg holds:
  - phase encodings PH_IDLE/PH_ENC/PH_DEC/PH_DONE
  - constants NR_128=10, NR_192=12, NR_256=14
  - function nr_of(mode)
  - function sw_to_mode(SW) (11 -> 0)
- No sub-module needed; the single FSM plus round counter stays under about 200 lines.

Test Plan:
1. SW=00, step_mode=0, start pulse:
   - busy rises the next cycle.
   - rk_index runs 0..10 then 10..0.
   - done pulses exactly 22 edges after the start edge.
   - pass=1 with match=1.
2. SW=10, step_mode=1, 5 step pulses spaced 3 cycles:
   - round=5, disp_round=5, phase=ENC; outputs hold between steps.
   - Then 25 more steps -> done; disp_round=29.
3. SW=01 at start, then SW switched to 10 mid-run:
   - mode stays 1.
   - last_round asserts at round 12 in both phases.
4. rst=0 during DEC round 4:
   - Next cycle phase=IDLE, all outputs 0, no done pulse.
   - A fresh start then completes normally.
5. start held high through a run:
   - No restart while busy.
   - The run restarts from DONE on the edge after done; pass clears.
6. SW=11 -> mode 0 (Nr=10); match=0 on the final DEC edge -> pass=0 while done=1.
